// File: rtl/watch_ctrl_pkg.sv
// watch_ctrl_pkg: shared encodings for the watch button front end
package watch_ctrl_pkg;
  typedef enum logic [1:0] {
    FIELD_HOUR = 2'd0,
    FIELD_MIN  = 2'd1,
    FIELD_SEC  = 2'd2
  } field_e;
  typedef enum logic {
    MODE_RUN = 1'b0,
    MODE_SET = 1'b1
  } mode_e;
  localparam int NBTN   = 4;
  localparam int P_STOP = 0;
  localparam int P_NEXT = 1;
  localparam int P_INC  = 2;
  localparam int P_DEC  = 3;
  function automatic field_e next_field(input field_e f);
    return f == FIELD_HOUR ? FIELD_MIN : f == FIELD_MIN ? FIELD_SEC : FIELD_HOUR;
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronises a raw button, filters bounce and flags debounced presses
module btn_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DB_CYCLES);
  logic meta, sync, flip;
  logic [CW-1:0] cnt;
  assign flip = (sync != level) && (cnt == CW'(DB_CYCLES - 1));
  // two-stage synchroniser feeding a run-length filter; a rising flip is a press
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      meta  <= raw;
      sync  <= meta;
      cnt   <= (sync == level || flip) ? '0 : cnt + 1'b1;
      level <= level ^ flip;
      press <= flip & sync;
    end
endmodule

// File: rtl/watch_button_ctrl.sv
// watch_button_ctrl: debounced, arbitrated single-pulse command front end for the watch core
module watch_button_ctrl
  import watch_ctrl_pkg::*;
#(
  parameter int DB_CYCLES    = 4,
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_stop_run,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       btn_next,
  output logic       stop_run,
  output logic       inc,
  output logic       dec,
  output logic       next,
  output logic       set_mode,
  output logic [1:0] field
);
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam logic [RW-1:0] RPT_FIRE = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RPT_WRAP = RW'(REPEAT_DELAY - REPEAT_RATE + 1);

  logic [NBTN-1:0] raw, level, press, evt, req, gnt, pend;
  logic [P_DEC:P_INC] rep_ok, rep_fire;
  logic [RW-1:0] rpt_cnt [P_INC:P_DEC];
  logic both_held, in_set;
  mode_e mode;
  field_e fld;

  assign raw[P_STOP] = btn_stop_run;
  assign raw[P_NEXT] = btn_next;
  assign raw[P_INC]  = btn_inc;
  assign raw[P_DEC]  = btn_dec;

  for (genvar i = 0; i < NBTN; i++) begin : g_db
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk(clk),
      .rst(rst),
      .raw(raw[i]),
      .level(level[i]),
      .press(press[i])
    );
  end

  assign in_set    = (mode == MODE_SET);
  assign both_held = level[P_INC] & level[P_DEC];

  // repeat timers only run while exactly one of inc/dec is held in SET mode
  always_comb begin
    rep_ok   = '0;
    rep_fire = '0;
    for (int b = P_INC; b <= P_DEC; b++) begin
      rep_ok[b]   = in_set & level[b] & ~both_held;
      rep_fire[b] = rep_ok[b] & (rpt_cnt[b] == RPT_FIRE);
    end
  end

  assign evt[P_STOP] = press[P_STOP];
  assign evt[P_NEXT] = in_set & press[P_NEXT];
  assign evt[P_INC]  = in_set & (press[P_INC] | rep_fire[P_INC]);
  assign evt[P_DEC]  = in_set & (press[P_DEC] | rep_fire[P_DEC]);
  assign req = pend | evt;
  assign gnt = req & (~req + 4'd1);

  // timer counts from the initial pulse, fires at REPEAT_DELAY then wraps to fire every REPEAT_RATE
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rpt_cnt[P_INC] <= '0;
      rpt_cnt[P_DEC] <= '0;
    end else
      for (int b = P_INC; b <= P_DEC; b++)
        rpt_cnt[b] <= !rep_ok[b] ? '0
                    : (gnt[b] && rpt_cnt[b] == '0) ? RW'(1)
                    : rep_fire[b] ? RPT_WRAP
                    : (rpt_cnt[b] != '0) ? rpt_cnt[b] + 1'b1 : '0;

  // mode/field state, pending flags and registered command pulses
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      stop_run <= 1'b0;
      next     <= 1'b0;
      inc      <= 1'b0;
      dec      <= 1'b0;
      pend     <= '0;
      mode     <= MODE_RUN;
      fld      <= FIELD_HOUR;
    end else begin
      stop_run <= gnt[P_STOP];
      next     <= gnt[P_NEXT];
      inc      <= gnt[P_INC];
      dec      <= gnt[P_DEC];
      pend     <= gnt[P_STOP] ? '0 : req & ~gnt;
      mode     <= gnt[P_STOP] ? (in_set ? MODE_RUN : MODE_SET) : mode;
      fld      <= (gnt[P_STOP] && !in_set) ? FIELD_HOUR : gnt[P_NEXT] ? next_field(fld) : fld;
    end

  assign set_mode = in_set;
  assign field    = fld;
endmodule

// File: doc/watch_button_ctrl.md
Name: watch_button_ctrl

Overview:
Front-end controller that sequences the hours/minutes/seconds watch core (hmsv2).
- Takes four raw, bouncy, asynchronous push buttons: stop_run, inc, dec, next.
- Synchronises, debounces and edge-detects them, then arbitrates so at most one single-cycle command pulse reaches the core per cycle.
- Auto-repeats held inc/dec in set mode.
- Tracks RUN/SET mode and the selected field (HOUR/MIN/SEC) for the display blink logic.

Parameters:
- DB_CYCLES, 4: consecutive stable synchronised samples required to accept a level change (>=2).
- REPEAT_DELAY, 16: cycles from the initial inc/dec pulse to the first auto-repeat event.
- REPEAT_RATE, 4: cycles between subsequent auto-repeat events.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- btn_stop_run  in  1  raw button, async, active-high.
- btn_inc  in  1  raw button, async, active-high.
- btn_dec  in  1  raw button, async, active-high.
- btn_next  in  1  raw button, async, active-high.
- stop_run  out  1  one-cycle command pulse to watch core.
- inc  out  1  one-cycle command pulse.
- dec  out  1  one-cycle command pulse.
- next  out  1  one-cycle command pulse.
- set_mode  out  1  0=RUN, 1=SET.
- field  out  2  0=HOUR, 1=MIN, 2=SEC; value 3 never driven.

Behaviour:
- Reset (rst=0, async): all pulse outputs, set_mode, field, debounced levels, pending flags and repeat counters cleared to 0.
  - A button held through reset release is seen as a fresh press after normal latency.
- Per button:
  - 2-FF synchroniser.
  - Debounce counter counts cycles where the synced value differs from the debounced level. Any agreeing sample clears it. After DB_CYCLES differing samples the debounced level flips.
  - Press event = debounced rising edge. Releases generate nothing.
- Latency: raw edge sampled at edge N gives output pulse high between edge N+DB_CYCLES+2 and N+DB_CYCLES+3, when uncontended. All outputs are registered.
- Pending: one-deep flag per button. An event sets it. A new event while set merges (no double count). The flag clears when its pulse issues.
- Arbitration: fixed priority stop_run > next > inc > dec. Exactly the highest pending flag issues each cycle. Losers wait.
- Mode gating:
  - In RUN, inc/dec/next events are discarded, not pended.
  - Issuing stop_run toggles set_mode on the same edge the pulse is registered, and clears the inc/dec/next pending flags.
  - Entering SET sets field=HOUR.
- field: each issued next advances HOUR->MIN->SEC->HOUR. Unchanged in RUN.
- Auto-repeat (SET only):
  - Repeat timer starts when the inc (or dec) initial pulse issues.
  - Events fire at +REPEAT_DELAY, then every REPEAT_RATE cycles, while the debounced level stays high.
  - Repeat events go through pending/arbitration like presses.
  - Release, leaving SET, or both inc and dec debounced-high stops and clears the timers.
- set_mode and field change only on issued pulses, never on raw inputs.

Decomposition:
- Package watch_ctrl_pkg:
  - field encodings FIELD_HOUR=2'd0, FIELD_MIN=2'd1, FIELD_SEC=2'd2;
  - priority index constants P_STOP, P_NEXT, P_INC, P_DEC;
  - mode constants MODE_RUN/MODE_SET.
- Sub-module btn_debounce (parameter DB_CYCLES; ports clk, rst, raw, level, press), instantiated four times.
- Arbiter, pending flags, repeat timers and mode/field FSM stay in watch_button_ctrl.

Test Plan:
1. Reset, then btn_stop_run rises (sampled at edge 10) and is held 10 cycles. Required: single stop_run pulse at edge 16; set_mode=1 and field=0 at edge 16; no further pulses.
2. In SET, btn_inc toggles every 2 cycles for 10 cycles, then stays high. Required: exactly one inc pulse, DB_CYCLES+2=6 edges after the final transition.
3. In SET, btn_next and btn_inc rise on the same edge. Required: next pulse at T and field 0->1; inc pulse at T+1; never both high in one cycle.
4. In SET, hold btn_inc 40 cycles. Required: inc at T, T+16, T+20, T+24, T+28, T+32, T+36; none after release. Repeat with btn_dec also held from T+5: no repeats after T+5.
5. In RUN, press inc and next. Required: no pulses and field unchanged. Then stop_run, then 3 next presses: field 0->1->2->0. Then pend inc behind a simultaneous stop_run: inc is discarded.
6. Pull rst low mid-hold with a pending inc. Required: outputs, set_mode and field go to 0 asynchronously. After release with the button still held, one inc press is seen after DB_CYCLES+2, but it is discarded because the mode is RUN.
